// File: rtl/excitation_burst_gen.sv
// Excitation burst generator: pulse burst, blanking, listen window, TOF capture.
// Define EXCITATION_BURST_GEN_ABORT_EN to add the abort input.
module excitation_burst_gen #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef EXCITATION_BURST_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic [7:0]       pulse_width,
  input  logic [7:0]       pulse_period,
  input  logic [NP_W-1:0]  num_pulses,
  input  logic [CNT_W-1:0] blank_len,
  input  logic [CNT_W-1:0] listen_len,
  input  logic             echo_trig,
  output logic             tx_out,
  output logic             rx_enable,
  output logic             busy,
  output logic [CNT_W-1:0] tof,
  output logic             tof_valid,
  output logic             timeout
);

  localparam int XW = (CNT_W > 9) ? CNT_W : 9;

  typedef enum logic [2:0] {
    IDLE,
    PULSE_HI,
    PULSE_LO,
    BLANK,
    LISTEN
  } state_t;

  state_t           state_q;
  logic [7:0]       cfg_w_q;
  logic [7:0]       cfg_p_q;
  logic [NP_W-1:0]  cfg_n_q;
  logic [CNT_W-1:0] cfg_b_q;
  logic [CNT_W-1:0] cfg_l_q;
  logic [XW-1:0]    cnt_q;
  logic [NP_W-1:0]  pcnt_q;
  logic [CNT_W-1:0] tb_q;
  logic [CNT_W-1:0] tof_q;
  logic             tx_q;
  logic             rx_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             to_q;

  logic [8:0]       w_eff;
  logic [8:0]       p_eff;
  logic [8:0]       lo_len;
  logic [CNT_W-1:0] post_b;
  logic [CNT_W-1:0] post_l;
  logic [CNT_W-1:0] tb_d;
  logic             hi_last;
  logic             lo_last;
  logic             pulse_last;
  logic             blank_last;
  logic             listen_last;
  logic             kill;

  always_comb begin
    w_eff = (cfg_w_q == 8'd0) ? 9'd1 : {1'b0, cfg_w_q};
    p_eff = {1'b0, cfg_p_q};
    if ({1'b0, cfg_p_q} <= w_eff) begin
      p_eff = w_eff + 9'd1;
    end
    lo_len = p_eff - w_eff;
  end

  // Leaving IDLE uses the live inputs; later moves use the captured config.
  always_comb begin
    post_b = cfg_b_q;
    post_l = cfg_l_q;
    if (state_q == IDLE) begin
      post_b = blank_len;
      post_l = listen_len;
    end
  end

  always_comb begin
    hi_last     = cnt_q == XW'(w_eff) - XW'(1);
    lo_last     = cnt_q == XW'(lo_len) - XW'(1);
    pulse_last  = pcnt_q == cfg_n_q - NP_W'(1);
    blank_last  = cnt_q == XW'(cfg_b_q) - XW'(1);
    listen_last = cnt_q == XW'(cfg_l_q) - XW'(1);
    tb_d        = (tb_q == '1) ? tb_q : tb_q + CNT_W'(1);
  end

`ifdef EXCITATION_BURST_GEN_ABORT_EN
  assign kill = abort && (state_q != IDLE);
`else
  assign kill = 1'b0;
`endif

  // LISTEN with done_q set is the strobe cycle: window closed, still busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_w_q <= '0;
      cfg_p_q <= '0;
      cfg_n_q <= '0;
      cfg_b_q <= '0;
      cfg_l_q <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      tb_q    <= '0;
      tof_q   <= '0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      if (busy_q) begin
        tb_q <= tb_d;
      end
      if (kill) begin
        state_q <= IDLE;
        tx_q    <= 1'b0;
        rx_q    <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              cfg_w_q <= pulse_width;
              cfg_p_q <= pulse_period;
              cfg_n_q <= num_pulses;
              cfg_b_q <= blank_len;
              cfg_l_q <= listen_len;
              busy_q  <= 1'b1;
              tb_q    <= '0;
              cnt_q   <= '0;
              pcnt_q  <= '0;
              if (num_pulses != '0) begin
                state_q <= PULSE_HI;
                tx_q    <= 1'b1;
              end else if (post_b != '0) begin
                state_q <= BLANK;
              end else begin
                state_q <= LISTEN;
                rx_q    <= post_l != '0;
                done_q  <= post_l == '0;
                to_q    <= post_l == '0;
              end
            end
          end
          PULSE_HI: begin
            if (hi_last) begin
              state_q <= PULSE_LO;
              tx_q    <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + XW'(1);
            end
          end
          PULSE_LO: begin
            if (!lo_last) begin
              cnt_q <= cnt_q + XW'(1);
            end else begin
              cnt_q <= '0;
              if (!pulse_last) begin
                state_q <= PULSE_HI;
                tx_q    <= 1'b1;
                pcnt_q  <= pcnt_q + NP_W'(1);
              end else if (post_b != '0) begin
                state_q <= BLANK;
              end else begin
                state_q <= LISTEN;
                rx_q    <= post_l != '0;
                done_q  <= post_l == '0;
                to_q    <= post_l == '0;
              end
            end
          end
          BLANK: begin
            if (blank_last) begin
              state_q <= LISTEN;
              cnt_q   <= '0;
              rx_q    <= cfg_l_q != '0;
              done_q  <= cfg_l_q == '0;
              to_q    <= cfg_l_q == '0;
            end else begin
              cnt_q <= cnt_q + XW'(1);
            end
          end
          LISTEN: begin
            if (done_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b0;
              cnt_q   <= '0;
            end else if (echo_trig) begin
              tof_q   <= tb_q;
              valid_q <= 1'b1;
              rx_q    <= 1'b0;
              done_q  <= 1'b1;
            end else if (listen_last) begin
              to_q    <= 1'b1;
              rx_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + XW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_out    = tx_q;
  assign rx_enable = rx_q;
  assign busy      = busy_q;
  assign tof       = tof_q;
  assign tof_valid = valid_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_excitation_burst_gen.sv
// Randomized bench for excitation_burst_gen against a per-cycle timeline model.
// Abort scenario is compiled in when EXCITATION_BURST_GEN_ABORT_EN is defined.
module tb_excitation_burst_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
`ifdef EXCITATION_BURST_GEN_ABORT_EN
  logic        abort;
`endif
  logic [7:0]  pulse_width;
  logic [7:0]  pulse_period;
  logic [7:0]  num_pulses;
  logic [15:0] blank_len;
  logic [15:0] listen_len;
  logic        echo_trig;
  logic        tx_out;
  logic        rx_enable;
  logic        busy;
  logic [15:0] tof;
  logic        tof_valid;
  logic        timeout;

  typedef struct packed {
    logic        tx;
    logic        rx;
    logic        bz;
    logic        v;
    logic        to;
    logic [15:0] tof;
  } sample_t;

  int      tests;
  int      fails;
  int      tof_m;
  sample_t obs_q[$];
  sample_t exp_q[$];

  excitation_burst_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef EXCITATION_BURST_GEN_ABORT_EN
    .abort        (abort),
`endif
    .pulse_width  (pulse_width),
    .pulse_period (pulse_period),
    .num_pulses   (num_pulses),
    .blank_len    (blank_len),
    .listen_len   (listen_len),
    .echo_trig    (echo_trig),
    .tx_out       (tx_out),
    .rx_enable    (rx_enable),
    .busy         (busy),
    .tof          (tof),
    .tof_valid    (tof_valid),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sample_t grab();
    sample_t s;
    s.tx  = tx_out;
    s.rx  = rx_enable;
    s.bz  = busy;
    s.v   = tof_valid;
    s.to  = timeout;
    s.tof = tof;
    return s;
  endfunction

  // Timeline model: t = 0 is the first cycle after the start edge.
  task automatic do_run(input int w, input int p, input int n,
                        input int b, input int l, input int e1,
                        input int e2, input bit rs);
    int we, pe, burst, l0, hit, ts;
    sample_t s;
    we    = (w == 0) ? 1 : w;
    pe    = (p <= we) ? we + 1 : p;
    burst = n * pe;
    l0    = burst + b;
    hit   = -1;
    if (e1 >= l0 && e1 < l0 + l) hit = e1;
    if (e2 >= l0 && e2 < l0 + l && (hit < 0 || e2 < hit)) hit = e2;
    ts = (hit >= 0) ? hit + 1 : l0 + l;
    obs_q.delete();
    exp_q.delete();
    for (int t = 0; t <= ts + 1; t++) begin
      s.tx  = (t < burst) && ((t % pe) < we);
      s.rx  = (t >= l0) && (t < l0 + l) && (hit < 0 || t <= hit);
      s.bz  = t <= ts;
      s.v   = (hit >= 0) && (t == ts);
      s.to  = (hit < 0) && (t == ts);
      s.tof = 16'((hit >= 0 && t >= ts) ? hit : tof_m);
      exp_q.push_back(s);
    end
    @(negedge clk);
    pulse_width  = 8'(w);
    pulse_period = 8'(p);
    num_pulses   = 8'(n);
    blank_len    = 16'(b);
    listen_len   = 16'(l);
    start        = 1'b1;
    for (int t = 0; t <= ts + 1; t++) begin
      @(posedge clk);
      #1;
      start        = (rs && t <= ts) ? 1'($urandom) : 1'b0;
      echo_trig    = (t == e1) || (t == e2);
      pulse_width  = 8'($urandom);
      pulse_period = 8'($urandom);
      num_pulses   = 8'($urandom);
      blank_len    = 16'($urandom);
      listen_len   = 16'($urandom);
      @(negedge clk);
      obs_q.push_back(grab());
    end
    start     = 1'b0;
    echo_trig = 1'b0;
    if (hit >= 0) tof_m = hit;
  endtask

  task automatic test_reset();
    sample_t z;
    z = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (grab() !== z) begin
      fails++;
      $display("FAIL reset_hold got %h exp %h", grab(), z);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (grab() !== z) begin
      fails++;
      $display("FAIL reset_idle got %h exp %h", grab(), z);
    end
  endtask

  task automatic test_nominal();
    do_run(3, 5, 4, 10, 50, 40, -1, 1'b0);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL nominal t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
    tests++;
    if (tof !== 16'd40) begin
      fails++;
      $display("FAIL nominal_tof got %0d exp 40", tof);
    end
  endtask

  task automatic test_timeout();
    do_run(1, 2, 2, 0, 8, -1, -1, 1'b0);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL timeout t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
  endtask

  task automatic test_degenerate();
    do_run(0, 0, 3, 2, 4, 9, -1, 1'b0);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL degen t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
  endtask

  task automatic test_no_pulse();
    do_run(4, 9, 0, 3, 5, 3, -1, 1'b0);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL nopulse t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
    do_run(2, 3, 0, 0, 0, -1, -1, 1'b0);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL skipwin t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
  endtask

  // Burst 2x3=6, blank to 11, window 11..16: echo at 8 lands in BLANK, 16 is last.
  task automatic test_blank_late();
    do_run(1, 3, 2, 5, 6, 8, 16, 1'b1);
    foreach (exp_q[t]) begin
      tests++;
      if (obs_q[t] !== exp_q[t]) begin
        fails++;
        $display("FAIL late t=%0d got %h exp %h", t, obs_q[t], exp_q[t]);
      end
    end
  endtask

  task automatic test_random();
    int w, p, n, b, l, span;
    for (int i = 0; i < 30; i++) begin
      w = $urandom_range(0, 4);
      p = $urandom_range(0, 7);
      n = $urandom_range(0, 5);
      b = $urandom_range(0, 12);
      l = $urandom_range(0, 15);
      span = n * 9 + b + l + 2;
      do_run(w, p, n, b, l, $urandom_range(0, span),
             $urandom_range(0, span), 1'b1);
      foreach (exp_q[t]) begin
        tests++;
        if (obs_q[t] !== exp_q[t]) begin
          fails++;
          $display("FAIL rand%0d t=%0d got %h exp %h", i, t, obs_q[t], exp_q[t]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pulse_width  = 8'd4;
    pulse_period = 8'd6;
    num_pulses   = 8'd3;
    blank_len    = 16'd1;
    listen_len   = 16'd5;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_out !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre got tx=%b busy=%b exp 1 1", tx_out, busy);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (grab() !== sample_t'(0)) begin
      fails++;
      $display("FAIL arst_drop got %h exp 0", grab());
    end
    tof_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef EXCITATION_BURST_GEN_ABORT_EN
  // Burst 1x2, blank 2: window opens at t=4; abort+echo at t=6.
  task automatic test_abort();
    sample_t s;
    @(negedge clk);
    pulse_width  = 8'd1;
    pulse_period = 8'd2;
    num_pulses   = 8'd1;
    blank_len    = 16'd2;
    listen_len   = 16'd20;
    start        = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      abort     = (t == 6);
      echo_trig = (t == 6);
      @(negedge clk);
      s     = '0;
      s.tof = 16'(tof_m);
      s.bz  = t <= 6;
      s.tx  = t < 1;
      s.rx  = t >= 4 && t <= 6;
      tests++;
      if (grab() !== s) begin
        fails++;
        $display("FAIL abort t=%0d got %h exp %h", t, grab(), s);
      end
    end
    abort     = 1'b0;
    echo_trig = 1'b0;
  endtask
`endif

  initial begin
    tests        = 0;
    fails        = 0;
    tof_m        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
`ifdef EXCITATION_BURST_GEN_ABORT_EN
    abort        = 1'b0;
`endif
    pulse_width  = '0;
    pulse_period = '0;
    num_pulses   = '0;
    blank_len    = '0;
    listen_len   = '0;
    echo_trig    = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_degenerate();
    test_no_pulse();
    test_blank_late();
    test_random();
`ifdef EXCITATION_BURST_GEN_ABORT_EN
    test_abort();
`endif
    test_async_reset();
    test_nominal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
